hyperterm_tx_arbiter: RTL and testbench

Shares one RS-232 transmit line among NREQ byte-stream requesters, such as the debug dumper, the program loader echo and the status reporter. Owns baud timing and UART framing: start bit, 8 data bits LSB first, STOP_BITS stop bits. Round-robin grants with per-requester message lock, so a multi-byte message is never interleaved with another requester's bytes. Sits between the requesters and the board `tx` pin alongside the hyperterm link logic.

---
 rtl/hyperterm_pkg.sv | 13 +
 rtl/hyperterm_tx_arbiter_if.sv | 14 +
 rtl/hyperterm_tx_serializer.sv | 54 +++++
 rtl/hyperterm_tx_arbiter.sv | 93 +++++++++
 tb/tb_hyperterm_tx_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hyperterm_pkg.sv
// Shared types and frame-geometry helpers for the hyperterm transmit path.
package hyperterm_pkg;

  typedef enum logic {IDLE, SEND} state_t;

  localparam int DATA_BITS = 8;

  // One start bit, the data bits, then the stop bits.
  function automatic int frame_bits(input int stop_bits);
    return 1 + DATA_BITS + stop_bits;
  endfunction

endpackage

// File: rtl/hyperterm_tx_arbiter_if.sv
// Requester-side byte-stream bundle: one req/data/last/ack slot per requester.
interface hyperterm_tx_arbiter_if
  import hyperterm_pkg::*;
#(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]                req;
  logic [NREQ-1:0][DATA_BITS-1:0] data;
  logic [NREQ-1:0]                last;
  logic [NREQ-1:0]                ack;

  modport master (output req, data, last, input ack);
  modport slave  (input req, data, last, output ack);
endinterface

// File: rtl/hyperterm_tx_serializer.sv
// UART frame shifter: start bit, 8 data bits LSB first, STOP_BITS stop bits.
module hyperterm_tx_serializer
  import hyperterm_pkg::*;
#(
  parameter int BIT_CYCLES = 20000,
  parameter int STOP_BITS  = 2
) (
  input  logic                 clk_48,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] byte_in,
  output logic                 tx,
  output logic                 done
);
  localparam int             FB        = frame_bits(STOP_BITS);
  localparam int             BW        = $clog2(BIT_CYCLES);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BIT_CYCLES - 1);
  localparam logic [3:0]     BIT_LAST  = 4'(FB - 1);

  logic [BW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [FB-1:0] shreg;
  logic          active;
  logic          bit_end;

  // shreg[0] is the line; an idle register is all ones so tx rests high.
  assign tx      = shreg[0];
  assign bit_end = active && (baud_cnt == BAUD_LAST);
  assign done    = bit_end && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk_48) begin
    if (rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (load) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= {{STOP_BITS{1'b1}}, byte_in, 1'b0};
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        bit_cnt  <= done ? 4'd0 : bit_cnt + 4'd1;
        shreg    <= {1'b1, shreg[FB-1:1]};
        if (done) active <= 1'b0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/hyperterm_tx_arbiter.sv
// Round-robin arbiter with per-requester message lock feeding one UART transmitter.
module hyperterm_tx_arbiter
  import hyperterm_pkg::*;
#(
  parameter int  NREQ       = 4,
  parameter int  BIT_CYCLES = 20000,
  parameter int  STOP_BITS  = 2,
  localparam int IW         = $clog2(NREQ)
) (
  input  logic                   clk_48,
  input  logic                   rst,
  hyperterm_tx_arbiter_if.slave  rq,
  input  logic                   tx_en,
  output logic                   tx,
  output logic                   busy,
  output logic [IW-1:0]          grant_id,
  output logic                   locked
);
  state_t          state, next_state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   winner;
  logic            found;
  logic            start;
  logic            done;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] ack_q;

  assign rq.ack = ack_q;

  // A locked message narrows eligibility to its owner; the rr scan then
  // trivially lands on grant_id.
  always_comb begin
    eligible = locked ? (rq.req & (NREQ'(1) << grant_id)) : rq.req;
    found    = 1'b0;
    winner   = rr_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && eligible[(int'(rr_ptr) + i) % NREQ]) begin
        found  = 1'b1;
        winner = IW'((int'(rr_ptr) + i) % NREQ);
      end
    end
  end

  assign start = (state == IDLE) && tx_en && found;

  always_ff @(posedge clk_48) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SEND;
      SEND:    if (done)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SEND);
  end

  always_ff @(posedge clk_48) begin
    if (rst) begin
      ack_q    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      locked   <= 1'b0;
    end else begin
      ack_q <= '0;
      if (start) begin
        ack_q[winner] <= 1'b1;
        grant_id      <= winner;
        rr_ptr        <= IW'((int'(winner) + 1) % NREQ);
        locked        <= ~rq.last[winner];
      end
    end
  end

  hyperterm_tx_serializer #(
    .BIT_CYCLES (BIT_CYCLES),
    .STOP_BITS  (STOP_BITS)
  ) u_ser (
    .clk_48  (clk_48),
    .rst     (rst),
    .load    (start),
    .byte_in (rq.data[winner]),
    .tx      (tx),
    .done    (done)
  );

endmodule

// File: tb/tb_hyperterm_tx_arbiter.sv
// Directed bench for hyperterm_tx_arbiter with NREQ=4, BIT_CYCLES=4, STOP_BITS=2 (F=44).
module tb_hyperterm_tx_arbiter;

  logic       clk_48 = 1'b0;
  logic       rst    = 1'b1;
  logic       tx_en  = 1'b1;
  logic       tx, busy, locked;
  logic [1:0] grant_id;

  int vec_cnt = 0;
  int err_cnt = 0;

  hyperterm_tx_arbiter_if #(.NREQ(4)) rq ();

  hyperterm_tx_arbiter #(
    .NREQ       (4),
    .BIT_CYCLES (4),
    .STOP_BITS  (2)
  ) dut (
    .clk_48   (clk_48),
    .rst      (rst),
    .rq       (rq),
    .tx_en    (tx_en),
    .tx       (tx),
    .busy     (busy),
    .grant_id (grant_id),
    .locked   (locked)
  );

  always #5 clk_48 = ~clk_48;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_48);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    rq.req   = '0;
    rq.last  = '0;
    rq.data  = '0;
    tx_en    = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Returns cycles waited to the first nonzero ack, or -1 when the budget runs out.
  task automatic wait_any_ack(input int budget, output int cyc, output logic [3:0] a);
    bit seen = 0;
    cyc = -1;
    a   = '0;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(negedge clk_48);
      if (rq.ack != 4'b0) begin
        seen = 1;
        cyc  = i;
        a    = rq.ack;
      end
    end
  endtask

  task automatic test_reset();
    rq.req  = '1;
    rq.last = '1;
    rq.data = {8'h44, 8'h33, 8'h22, 8'h11};
    tx_en   = 1'b1;
    rst     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      vec_cnt++;
      if ({tx, rq.ack, busy, locked} !== 7'b1_0000_0_0) begin
        err_cnt++;
        $display("FAIL reset_hold[%0d]: tx/ack/busy/locked got %b want 1000000", i,
                 {tx, rq.ack, busy, locked});
      end
    end
    rst = 1'b0;
    tick(1);
    vec_cnt++;
    if ({rq.ack, tx, busy, grant_id} !== {4'b0001, 1'b0, 1'b1, 2'd0}) begin
      err_cnt++;
      $display("FAIL reset_first_grant: ack/tx/busy/gid got %b want 00010100",
               {rq.ack, tx, busy, grant_id});
    end
    rq.req = '0;
    tick(1);
    vec_cnt++;
    if (rq.ack !== 4'b0) begin
      err_cnt++;
      $display("FAIL reset_ack_pulse: ack got %b want 0000", rq.ack);
    end
  endtask

  task automatic test_single_frame();
    logic [10:0] exp_bits = 11'b11011001010;  // 0x65 framed, bit 0 = start
    do_reset();
    rq.data[0] = 8'h65;
    rq.last[0] = 1'b1;
    rq.req     = 4'b0001;
    tick(1);
    vec_cnt++;
    if (rq.ack !== 4'b0001) begin
      err_cnt++;
      $display("FAIL single_ack: ack got %b want 0001", rq.ack);
    end
    rq.req = '0;
    for (int c = 0; c < 44; c++) begin
      if (c != 0) tick(1);
      vec_cnt++;
      if ({busy, tx} !== {1'b1, exp_bits[c/4]}) begin
        err_cnt++;
        $display("FAIL single_bits c=%0d: busy/tx got %b want %b", c, {busy, tx},
                 {1'b1, exp_bits[c/4]});
      end
      if (c != 0) begin
        vec_cnt++;
        if (rq.ack !== 4'b0) begin
          err_cnt++;
          $display("FAIL single_no_ack c=%0d: ack got %b want 0000", c, rq.ack);
        end
      end
    end
    tick(1);
    vec_cnt++;
    if ({busy, tx} !== 2'b01) begin
      err_cnt++;
      $display("FAIL single_idle: busy/tx got %b want 01", {busy, tx});
    end
  endtask

  task automatic test_round_robin();
    int         exp_id[4] = '{0, 2, 3, 0};
    int         cyc;
    logic [3:0] a;
    do_reset();
    rq.last = '1;
    rq.data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    rq.req  = 4'b1101;
    for (int g = 0; g < 4; g++) begin
      wait_any_ack(60, cyc, a);
      vec_cnt++;
      if (a !== 4'(1 << exp_id[g]) || grant_id !== 2'(exp_id[g])) begin
        err_cnt++;
        $display("FAIL rr_order g=%0d: ack/gid got %b/%0d want %b/%0d", g, a, grant_id,
                 4'(1 << exp_id[g]), exp_id[g]);
      end
      vec_cnt++;
      if (cyc != ((g == 0) ? 1 : 45)) begin
        err_cnt++;
        $display("FAIL rr_spacing g=%0d: cycles got %0d want %0d", g, cyc,
                 (g == 0) ? 1 : 45);
      end
    end
    rq.req = '0;
  endtask

  task automatic test_lock();
    int         cyc;
    logic [3:0] a;
    do_reset();
    rq.data[1] = 8'hA1;
    rq.last[1] = 1'b0;
    rq.req     = 4'b0010;
    wait_any_ack(10, cyc, a);
    vec_cnt++;
    if (a !== 4'b0010 || locked !== 1'b1) begin
      err_cnt++;
      $display("FAIL lock_b1: ack/locked got %b/%b want 0010/1", a, locked);
    end
    tick(5);
    rq.req[0]  = 1'b1;
    rq.last[0] = 1'b1;
    rq.data[0] = 8'h0F;
    rq.data[1] = 8'hA2;
    vec_cnt++;
    if (locked !== 1'b1) begin
      err_cnt++;
      $display("FAIL lock_mid: locked got %b want 1", locked);
    end
    wait_any_ack(60, cyc, a);
    vec_cnt++;
    if (a !== 4'b0010 || locked !== 1'b1 || cyc != 40) begin
      err_cnt++;
      $display("FAIL lock_b2: ack/locked/cyc got %b/%b/%0d want 0010/1/40", a, locked, cyc);
    end
    rq.data[1] = 8'hA3;
    rq.last[1] = 1'b1;
    wait_any_ack(60, cyc, a);
    vec_cnt++;
    if (a !== 4'b0010 || locked !== 1'b0) begin
      err_cnt++;
      $display("FAIL lock_b3: ack/locked got %b/%b want 0010/0", a, locked);
    end
    rq.req[1] = 1'b0;
    wait_any_ack(60, cyc, a);
    vec_cnt++;
    if (a !== 4'b0001 || cyc != 45) begin
      err_cnt++;
      $display("FAIL lock_release: ack/cyc got %b/%0d want 0001/45", a, cyc);
    end
    rq.req = '0;
  endtask

  task automatic test_lock_hold();
    int         cyc;
    logic [3:0] a;
    do_reset();
    rq.data[2] = 8'h5C;
    rq.last[2] = 1'b0;
    rq.req     = 4'b0100;
    wait_any_ack(10, cyc, a);
    rq.data[0] = 8'h99;
    rq.last[0] = 1'b1;
    rq.req     = 4'b0001;
    wait_any_ack(150, cyc, a);
    vec_cnt++;
    if (cyc != -1 || locked !== 1'b1 || grant_id !== 2'd2 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL hold_blocked: cyc/locked/gid/busy got %0d/%b/%0d/%b want -1/1/2/0",
               cyc, locked, grant_id, busy);
    end
    rq.last[2] = 1'b1;
    rq.req     = 4'b0101;
    wait_any_ack(5, cyc, a);
    vec_cnt++;
    if (a !== 4'b0100 || cyc != 1 || locked !== 1'b0) begin
      err_cnt++;
      $display("FAIL hold_resume: ack/cyc/locked got %b/%0d/%b want 0100/1/0", a, cyc, locked);
    end
    rq.req[2] = 1'b0;
    wait_any_ack(60, cyc, a);
    vec_cnt++;
    if (a !== 4'b0001 || cyc != 45) begin
      err_cnt++;
      $display("FAIL hold_next: ack/cyc got %b/%0d want 0001/45", a, cyc);
    end
    rq.req = '0;
  endtask

  task automatic test_flow_control();
    int         cyc;
    int         stray = 0;
    logic [3:0] a;
    do_reset();
    rq.data[2] = 8'h3C;
    rq.last[2] = 1'b1;
    rq.req     = 4'b0100;
    wait_any_ack(10, cyc, a);
    vec_cnt++;
    if (a !== 4'b0100) begin
      err_cnt++;
      $display("FAIL flow_first: ack got %b want 0100", a);
    end
    tick(12);
    tx_en = 1'b0;
    for (int c = 13; c <= 80; c++) begin
      tick(1);
      if (rq.ack != 4'b0) stray++;
      if (c == 43) begin
        vec_cnt++;
        if (busy !== 1'b1) begin
          err_cnt++;
          $display("FAIL flow_busy_tail: busy got %b want 1", busy);
        end
      end
      if (c == 44) begin
        vec_cnt++;
        if ({busy, tx} !== 2'b01) begin
          err_cnt++;
          $display("FAIL flow_complete: busy/tx got %b want 01", {busy, tx});
        end
      end
    end
    vec_cnt++;
    if (stray != 0) begin
      err_cnt++;
      $display("FAIL flow_no_ack: acks seen %0d want 0", stray);
    end
    tx_en = 1'b1;
    tick(1);
    vec_cnt++;
    if (rq.ack !== 4'b0100 || tx !== 1'b0) begin
      err_cnt++;
      $display("FAIL flow_resume: ack/tx got %b/%b want 0100/0", rq.ack, tx);
    end
    tick(1);
    vec_cnt++;
    if (rq.ack !== 4'b0) begin
      err_cnt++;
      $display("FAIL flow_pulse: ack got %b want 0000", rq.ack);
    end
    rq.req = '0;
  endtask

  task automatic test_reset_mid();
    int         cyc;
    logic [3:0] a;
    do_reset();
    rq.data[3] = 8'h52;
    rq.last[3] = 1'b0;
    rq.req     = 4'b1000;
    wait_any_ack(10, cyc, a);
    vec_cnt++;
    if (a !== 4'b1000 || locked !== 1'b1 || grant_id !== 2'd3) begin
      err_cnt++;
      $display("FAIL rmid_start: ack/locked/gid got %b/%b/%0d want 1000/1/3", a, locked, grant_id);
    end
    rq.data[1] = 8'h77;
    rq.last[1] = 1'b1;
    rq.req     = 4'b1010;
    tick(17);
    vec_cnt++;
    if ({busy, tx} !== 2'b10) begin
      err_cnt++;
      $display("FAIL rmid_bit4: busy/tx got %b want 10", {busy, tx});
    end
    rst = 1'b1;
    tick(1);
    vec_cnt++;
    if ({tx, rq.ack, busy, locked, grant_id} !== 9'b1_0000_0_0_00) begin
      err_cnt++;
      $display("FAIL rmid_reset: tx/ack/busy/locked/gid got %b want 100000000",
               {tx, rq.ack, busy, locked, grant_id});
    end
    rst = 1'b0;
    tick(1);
    vec_cnt++;
    if (rq.ack !== 4'b0010 || grant_id !== 2'd1 || locked !== 1'b0) begin
      err_cnt++;
      $display("FAIL rmid_regrant: ack/gid/locked got %b/%0d/%b want 0010/1/0",
               rq.ack, grant_id, locked);
    end
    rq.req = '0;
  endtask

  initial begin
    rq.req  = '0;
    rq.last = '0;
    rq.data = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_lock();
    test_lock_hold();
    test_flow_control();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
